// File: rtl/alu_vec_sequencer.sv
// Self-checking stimulus sequencer for the NAND/ROL ALU family: issues NUM_VEC
// arithmetic vectors under valid/ready, waits for each result and tallies mismatches.
module alu_vec_sequencer #(
  parameter int unsigned      WIDTH   = 7,
  parameter int unsigned      NUM_VEC = 8,
  parameter logic [WIDTH-1:0] SEED_A  = 7'h55,
  parameter logic [WIDTH-1:0] SEED_B  = 7'h2A,
  parameter int unsigned      INC_A   = 1,
  parameter int unsigned      INC_B   = 3,
  parameter int unsigned      TIMEOUT = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic [WIDTH-1:0]               a,
  output logic [WIDTH-1:0]               b,
  output logic [1:0]                     op,
  output logic                           vec_vld,
  input  logic                           vec_rdy,
  input  logic [WIDTH-1:0]               res,
  input  logic                           res_vld,
  output logic                           busy,
  output logic                           done,
  output logic                           pass,
  output logic [$clog2(NUM_VEC+1)-1:0]   fail_cnt,
  output logic [$clog2(NUM_VEC+1)-1:0]   vec_idx,
  output logic                           timeout_err
);

  localparam int unsigned CW = $clog2(NUM_VEC + 1);
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] FAIL_MAX = CW'(NUM_VEC);
  localparam logic [CW-1:0] IDX_LAST = CW'(NUM_VEC - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, DONE} state_t;

  state_t           state;
  logic [TW-1:0]    tmo;
  logic [WIDTH-1:0] res_cap;
  logic             mismatch;
  logic             timed_out;
  logic             step;
  logic [CW-1:0]    fail_inc;
  logic [CW-1:0]    fail_step;

  function automatic logic [WIDTH-1:0] ref_model(input logic [WIDTH-1:0] av,
                                                 input logic [WIDTH-1:0] bv,
                                                 input logic [1:0]       ov);
    logic [2*WIDTH-1:0] dbl;
    int unsigned        s;
    s   = 32'(bv) % WIDTH;
    dbl = {av, av};
    case (ov)
      2'b00:   return ~(av & bv);
      2'b01: begin
        dbl = dbl << s;
        return dbl[2*WIDTH-1:WIDTH];
      end
      2'b10: begin
        dbl = dbl >> s;
        return dbl[WIDTH-1:0];
      end
      default: return av ^ bv;
    endcase
  endfunction

  // a/b/op hold the current vector through WAIT and CHECK, so the model reads them directly.
  always_comb begin
    mismatch  = (res_cap != ref_model(a, b, op));
    timed_out = (state == WAIT) && !res_vld && (tmo == TMO_LAST);
    step      = timed_out || (state == CHECK);
    fail_inc  = (fail_cnt == FAIL_MAX) ? fail_cnt : fail_cnt + CW'(1);
    fail_step = ((state == CHECK) && !mismatch) ? fail_cnt : fail_inc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      a           <= '0;
      b           <= '0;
      op          <= '0;
      vec_vld     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_cnt    <= '0;
      vec_idx     <= '0;
      timeout_err <= 1'b0;
      tmo         <= '0;
      res_cap     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= ISSUE;
            a           <= SEED_A;
            b           <= SEED_B;
            op          <= '0;
            vec_vld     <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_cnt    <= '0;
            vec_idx     <= '0;
            timeout_err <= 1'b0;
          end
        end
        ISSUE: begin
          if (vec_rdy) begin
            vec_vld <= 1'b0;
            tmo     <= '0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (res_vld) begin
            res_cap <= res;
            state   <= CHECK;
          end else if (tmo != TMO_LAST) begin
            tmo <= tmo + TW'(1);
          end
        end
        default: ;
      endcase

      // Shared next-vector step for both CHECK and a WAIT timeout.
      if (step) begin
        fail_cnt <= fail_step;
        if (timed_out) timeout_err <= 1'b1;
        if (vec_idx == IDX_LAST) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= (fail_step == '0);
          a     <= '0;
          b     <= '0;
          op    <= '0;
        end else begin
          state   <= ISSUE;
          vec_idx <= vec_idx + CW'(1);
          a       <= a + WIDTH'(INC_A);
          b       <= b + WIDTH'(INC_B);
          op      <= op + 2'd1;
          vec_vld <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_vec_sequencer.sv
// Directed bench for alu_vec_sequencer: default instance with a table-driven ALU
// model, plus a small 2-vector instance whose ALU returns a wrong ROL result.
module tb_alu_vec_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // default-parameter instance
  logic       start = 1'b0;
  logic [6:0] a, b;
  logic [1:0] op;
  logic       vec_vld;
  logic       vec_rdy = 1'b1;
  logic [6:0] res = '0;
  logic       res_vld = 1'b0;
  logic       busy, done, pass, timeout_err;
  logic [3:0] fail_cnt, vec_idx;

  alu_vec_sequencer u0 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .op(op),
    .vec_vld(vec_vld), .vec_rdy(vec_rdy), .res(res), .res_vld(res_vld),
    .busy(busy), .done(done), .pass(pass), .fail_cnt(fail_cnt),
    .vec_idx(vec_idx), .timeout_err(timeout_err)
  );

  // small instance: A fixed at 1110000, B counting up from 2
  logic       start1 = 1'b0;
  logic [6:0] a1, b1;
  logic [1:0] op1;
  logic       vec_vld1;
  logic       vec_rdy1 = 1'b1;
  logic [6:0] res1 = '0;
  logic       res_vld1 = 1'b0;
  logic       busy1, done1, pass1, timeout_err1;
  logic [1:0] fail_cnt1, vec_idx1;

  alu_vec_sequencer #(
    .WIDTH(7), .NUM_VEC(2), .SEED_A(7'b1110000), .SEED_B(7'b0000010),
    .INC_A(0), .INC_B(1), .TIMEOUT(16)
  ) u1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .op(op1),
    .vec_vld(vec_vld1), .vec_rdy(vec_rdy1), .res(res1), .res_vld(res_vld1),
    .busy(busy1), .done(done1), .pass(pass1), .fail_cnt(fail_cnt1),
    .vec_idx(vec_idx1), .timeout_err(timeout_err1)
  );

  typedef struct {
    logic [6:0] a;
    logic [6:0] b;
    logic [1:0] op;
    logic [6:0] exp;
  } vec_t;
  vec_t tbl [8];

  int checks = 0;
  int passed = 0;
  int stall_req = 0;
  int drop_idx = -1;

  // ALU model for u0: returns the hand-computed result one cycle after accept
  logic       pend = 1'b0;
  logic [6:0] pend_val = '0;
  int         stalled = 0;
  always @(negedge clk) begin
    res_vld = 1'b0;
    if (rst) begin
      pend    = 1'b0;
      vec_rdy = 1'b1;
      stalled = 0;
    end else begin
      if (pend) begin
        res_vld = 1'b1;
        res     = pend_val;
        pend    = 1'b0;
      end
      if (!vec_vld) stalled = 0;
      if (vec_vld && vec_idx == 4'd0 && stalled < stall_req) begin
        vec_rdy = 1'b0;
        stalled++;
      end else begin
        vec_rdy = 1'b1;
      end
      if (vec_vld && vec_rdy && int'(vec_idx) != drop_idx) begin
        pend     = 1'b1;
        pend_val = tbl[vec_idx[2:0]].exp;
      end
    end
  end

  // ALU model for u1: correct NAND for vector 0, wrong rotate (1000011) for vector 1
  logic       pend1 = 1'b0;
  logic [6:0] pv1 = '0;
  always @(negedge clk) begin
    res_vld1 = 1'b0;
    if (rst) begin
      pend1 = 1'b0;
    end else begin
      if (pend1) begin
        res_vld1 = 1'b1;
        res1     = pv1;
        pend1    = 1'b0;
      end
      if (vec_vld1) begin
        pend1 = 1'b1;
        pv1   = (vec_idx1 == 2'd0) ? 7'b1111111 : 7'b1000011;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    @(negedge clk);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_vec(input int k);
    int n = 0;
    while (!(vec_vld && int'(vec_idx) == k) && n < 200) begin
      tick();
      n++;
    end
    chk("wait_vec", 32'(n < 200), 32'd1);
  endtask

  task automatic wait_low;
    int n = 0;
    while (vec_vld && n < 200) begin
      tick();
      n++;
    end
    chk("wait_accept", 32'(n < 200), 32'd1);
  endtask

  task automatic wait_done;
    int n = 0;
    while (!done && n < 500) begin
      tick();
      n++;
    end
    chk("wait_done", 32'(n < 500), 32'd1);
  endtask

  initial begin
    int t0;
    int gap;
    logic [15:0] v1cap;

    tbl[0] = '{7'h55, 7'h2A, 2'd0, 7'h7F};
    tbl[1] = '{7'h56, 7'h2D, 2'd1, 7'h35};
    tbl[2] = '{7'h57, 7'h30, 2'd2, 7'h2F};
    tbl[3] = '{7'h58, 7'h33, 2'd3, 7'h6B};
    tbl[4] = '{7'h59, 7'h36, 2'd0, 7'h6F};
    tbl[5] = '{7'h5A, 7'h39, 2'd1, 7'h35};
    tbl[6] = '{7'h5B, 7'h3C, 2'd2, 7'h5D};
    tbl[7] = '{7'h5C, 7'h3F, 2'd3, 7'h63};

    // reset state
    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'({a, b, op, vec_vld, busy, done, pass, fail_cnt, vec_idx, timeout_err}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("idle_after_reset", 32'({busy, done, vec_vld}), 32'd0);

    // run 1: ideal ALU, every issued vector against the table, total latency
    pulse_start();
    t0 = cyc;
    for (int k = 0; k < 8; k++) begin
      wait_vec(k);
      chk($sformatf("vec%0d_abop", k), 32'({a, b, op}), 32'({tbl[k].a, tbl[k].b, tbl[k].op}));
    end
    wait_done();
    chk("run1_cycles", 32'(cyc - t0), 32'd24);
    chk("run1_result", 32'({done, pass, busy, timeout_err, fail_cnt}), 32'({4'b1100, 4'd0}));
    chk("run1_done_abop", 32'({a, b, op}), 32'd0);

    // run 2: restart from DONE with vec_rdy stalled 5 cycles on vector 0
    stall_req = 5;
    pulse_start();
    chk("restart_clear", 32'({vec_vld, done, pass, fail_cnt, vec_idx, a}),
        32'({1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 7'h55}));
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk($sformatf("stall_stable%0d", i), 32'({vec_vld, a, b, op}),
          32'({1'b1, tbl[0].a, tbl[0].b, tbl[0].op}));
    end
    tick();
    chk("stall_accept", 32'(vec_vld), 32'd0);
    stall_req = 0;
    wait_vec(3);
    pulse_start();
    chk("midrun_start_ignored", 32'({vec_vld, busy, vec_idx}), 32'({1'b0, 1'b1, 4'd3}));
    wait_done();
    chk("run2_result", 32'({done, pass, fail_cnt}), 32'({2'b11, 4'd0}));

    // run 3: vector 2 never answered
    drop_idx = 2;
    pulse_start();
    wait_vec(2);
    wait_low();
    gap = 0;
    while (!vec_vld && gap < 100) begin
      gap++;
      tick();
    end
    chk("timeout_wait_cycles", 32'(gap), 32'd16);
    chk("timeout_flags", 32'({timeout_err, fail_cnt, vec_idx}), 32'({1'b1, 4'd1, 4'd3}));
    drop_idx = -1;
    wait_done();
    chk("run3_result", 32'({done, pass, timeout_err, fail_cnt}), 32'({3'b101, 4'd1}));

    // run 4: asynchronous reset while waiting on vector 1
    pulse_start();
    wait_vec(1);
    wait_low();
    #2 rst = 1'b1;
    #1;
    chk("async_reset_outputs", 32'({a, b, op, vec_vld, busy, done, pass, fail_cnt, vec_idx, timeout_err}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("post_reset_idle", 32'({busy, done, vec_vld}), 32'd0);
    pulse_start();
    wait_done();
    chk("run4_result", 32'({done, pass, timeout_err, fail_cnt}), 32'({3'b110, 4'd0}));

    // small instance: wrong rotate result on vector 1
    v1cap = '1;
    @(negedge clk);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int n = 0; n < 100 && !done1; n++) begin
      if (vec_vld1 && vec_idx1 == 2'd1) v1cap = {a1, b1, op1};
      tick();
    end
    chk("u1_vec1_abop", 32'(v1cap), 32'({7'b1110000, 7'd3, 2'b01}));
    chk("u1_result", 32'({done1, pass1, timeout_err1, fail_cnt1}), 32'({3'b100, 2'd1}));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/alu_vec_sequencer.md
Name: alu_vec_sequencer

Overview:
Parametrised self-checking stimulus sequencer for the NAND/ROL ALU family. It generates NUM_VEC operand/opcode vectors arithmetically and issues each to the ALU under a valid/ready handshake. It waits for the ALU result with a timeout, compares the result against a built-in reference model, and reports a pass/fail summary. It sits beside the ALU in the self-test wrapper and replaces the fixed three-vector controller.

Parameters:
WIDTH, 7, operand/result width in bits (>=2)
NUM_VEC, 8, number of vectors per run (>=1)
SEED_A, 7'h55, operand A of vector 0
SEED_B, 7'h2A, operand B of vector 0
INC_A, 1, per-vector increment of A, modulo 2^WIDTH
INC_B, 3, per-vector increment of B, modulo 2^WIDTH
TIMEOUT, 16, maximum cycles to wait for res_vld (>=1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  single-cycle run request
a  out  WIDTH  operand A to ALU
b  out  WIDTH  operand B to ALU
op  out  2  opcode to ALU
vec_vld  out  1  vector valid
vec_rdy  in  1  ALU accepts vector
res  in  WIDTH  ALU result
res_vld  in  1  result valid (one cycle)
busy  out  1  run in progress
done  out  1  run complete (level, held)
pass  out  1  done and zero failures
fail_cnt  out  $clog2(NUM_VEC+1)  mismatching or timed-out vectors
vec_idx  out  $clog2(NUM_VEC+1)  index of current vector
timeout_err  out  1  sticky: any vector timed out this run

Behaviour:
- Interface: rst is asynchronous and active-high; clock is clk. Every output is registered.
- Reset values: a=b=0, op=0, vec_vld=0, busy=0, done=0, pass=0, fail_cnt=0, vec_idx=0, timeout_err=0. State=IDLE.
- Vector generation for vector k:
  - A_k = (SEED_A + k*INC_A) mod 2^WIDTH
  - B_k = (SEED_B + k*INC_B) mod 2^WIDTH
  - OP_k = k mod 4
- Reference model; shift amount s = B mod WIDTH:
  - 00: NAND, ~(A&B)
  - 01: ROL, A rotated left by s
  - 10: ROR, A rotated right by s
  - 11: XOR, A^B
- State machine: IDLE, ISSUE, WAIT, CHECK, DONE.
- IDLE:
  - start=1 -> ISSUE. On that transition, clear fail_cnt, vec_idx and timeout_err, and clear done/pass.
- ISSUE:
  - vec_vld=1, with a/b/op = vector vec_idx. Values stay stable while vec_vld=1 and vec_rdy=0.
  - The handshake completes on a clk edge with vec_vld&vec_rdy; vec_vld drops the next cycle.
  - Then -> WAIT, and the timeout counter loads 0.
- WAIT:
  - res_vld=1 -> capture res and go to CHECK.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 without res_vld: fail_cnt+1, timeout_err=1, skip CHECK, and go to the next-vector step.
- CHECK (one cycle):
  - Captured res != expected -> fail_cnt+1.
- Next-vector step:
  - vec_idx==NUM_VEC-1 -> DONE.
  - Otherwise vec_idx+1 -> ISSUE.
- DONE:
  - done=1, pass=(fail_cnt==0); both held.
  - a/b/op return to 0.
  - start=1 -> restart exactly as from IDLE.
- busy=1 in ISSUE, WAIT and CHECK.
- start is ignored while busy.
- res_vld outside WAIT is ignored and never counted.
- vec_rdy outside ISSUE is ignored.
- fail_cnt saturates at NUM_VEC; it cannot exceed NUM_VEC by construction.
- Reset mid-run: everything returns to its reset values immediately (asynchronously) and no partial result is reported.
- Minimum latency per vector, with vec_rdy and res_vld both immediate: 3 cycles (ISSUE, WAIT, CHECK).

Test Plan:
- Defaults, ideal ALU model (vec_rdy=1, res returned 1 cycle after accept), start pulse -> vector 0 is a=1010101, b=0101010, op=00 with expected 1111111; after 8 vectors: done=1, pass=1, fail_cnt=0.
- WIDTH=7, SEED_A=7'b1110000, SEED_B=7'b0000010, INC_B=1, NUM_VEC=2 -> vector 1 is op=01 with b=3, expected 0000111; an ALU that returns 1000011 gives fail_cnt=1, pass=0.
- vec_rdy held low 5 cycles during vector 0 -> a/b/op/vec_vld stable all 5 cycles; the run still passes.
- res_vld never asserted for vector 2, TIMEOUT=16 -> 16 cycles in WAIT, then timeout_err=1 and fail_cnt=1, and the sequencer continues to vector 3.
- start pulsed mid-run -> ignored; start pulsed in DONE -> counters clear and vector 0 is reissued.
- rst asserted during WAIT -> all outputs at their reset values the same cycle; the next start gives a clean, passing run.
